aes128_encrypt_core: RTL
========================

# aes128_encrypt_core

Iterative, column-serial AES-128 encryption engine (FIPS-197), the forward-direction counterpart of the team's round-serial AES-128 datapath. It accepts one 128-bit plaintext and key per start request and returns the ciphertext after a fixed latency. Round keys are expanded on the fly, one per round, alongside the data path. It slots into the same top level as a producer of ciphertext for the decryption path and for the self-test bench.

## Interface
- No parameters: fixed AES-128, Nk=4, Nr=10.
- clk  in  1  sole clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled on rising edge only when busy=0
- key  in  128  cipher key; sampled on the accepting edge only
- plaintext  in  128  input block; sampled on the accepting edge only
- busy  out  1  high while a block is in flight
- done  out  1  single-cycle pulse when ciphertext becomes valid
- ciphertext  out  128  result; held stable until the next accepted start

## Operation
- Byte order: bits [127:120] = byte 0. Column c = bits [127-32c -: 32]. Byte s[r][c] = byte 4c+r.
- FSM states:
  - IDLE: on start=1, go to ROUND.
    - state_reg <= plaintext ^ key.
    - rk_reg <= expand(key, rcon=01), i.e. round key 1.
    - round <= 1, col <= 0, busy <= 1.
  - ROUND: each cycle processes column col (0..3).
    - Build ShiftRows column from state_reg: bytes s[r][(col+r) mod 4], r=0..3.
    - Apply SubBytes with 4 S-boxes.
    - Apply MixColumns, bypassed when round==10.
    - XOR with rk_reg column col.
    - Write the result into next_reg column col.
  - ROUND, col<3: col <= col+1.
  - ROUND, col==3, round<10:
    - state_reg <= next_reg with column 3 taken from the current result (no extra cycle).
    - rk_reg <= expand(rk_reg, rcon[round+1]).
    - round <= round+1, col <= 0.
  - ROUND, col==3, round==10:
    - ciphertext <= the completed block.
    - done <= 1 for one cycle, busy <= 0, go to IDLE.
- Key expansion is combinational from rk_reg: RotWord, SubWord (4 dedicated S-boxes), XOR with rcon, then the chained XOR of w1..w3.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- MixColumns uses xtime = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 0). All arithmetic is 8-bit GF(2^8), with no width growth.
- start while busy=1 is ignored and not queued. key and plaintext changes while busy have no effect.

## Timing
- Reset values: busy=0, done=0, ciphertext=0, FSM=IDLE, round=0, col=0, state_reg=0, rk_reg=0.
- Let E0 be the rising edge that accepts start.
  - busy is high after E0 through E40.
  - ciphertext is updated and done=1 after E40. done drops after E41.
  - Latency is 40 clocks: 10 rounds × 4 columns.
- A new start can be accepted at E41 at the earliest: the done cycle is in IDLE, and start sampled at E41 is accepted.
- If done and an accepted start land in the same cycle, done still pulses. ciphertext holds until the next completion, not the next acceptance.
- rst asserted mid-operation aborts immediately:
  - Outputs and state return to their reset values asynchronously.
  - No done is produced.
  - The first start after rst deasserts is accepted normally.
- The round counter never exceeds 10. col wraps 3→0 only on round advance.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, done exactly 40 edges after acceptance, busy high for those 40 cycles.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32. Check the internal round-1 state after E4 equals a49c7ff2689f352b6b5bea43026a5049.
- All-zero key and pt → 66e94bd4ef8a2c3b884cfa59ca342b2e. Then key all-ff, pt all-ff → bcbf217cb280cf30b2517052193ab979.
- Start re-pulsed at E10 with different key/pt while busy → ignored. C.1 result is still produced at E40, and only one done pulse occurs.
- rst asserted at E20 of a C.1 run → busy=0, done=0, ciphertext=0 immediately. Rerun App. B afterwards → correct result at 40 cycles.
- Back-to-back: start held high continuously with C.1 then App. B vectors → second acceptance at E41, second done at E81, first ciphertext held during E41..E80.

Source files
------------

// File: rtl/aes128_encrypt_core_if.sv
// Request/response bundle for the AES-128 encryption core: start with key and
// plaintext in, busy/done status and the ciphertext out.
interface aes128_encrypt_core_if;
    logic         start;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic         busy;
    logic         done;
    logic [127:0] ciphertext;

    modport master (
        output start, key, plaintext,
        input  busy, done, ciphertext
    );

    modport slave (
        input  start, key, plaintext,
        output busy, done, ciphertext
    );
endinterface

// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryptor: one state column per clock, 10 rounds x 4 columns,
// with the next round key expanded on the fly from the current one.
module aes128_encrypt_core (
    input  logic                        clk,
    input  logic                        rst,
    aes128_encrypt_core_if.slave        bus
);

    typedef enum logic {IDLE, ROUND} fsm_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixColumn(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [7:0] getByte(input logic [127:0] blk, input logic [3:0] idx);
        int i;
        i = int'(idx);
        return blk[127 - 8*i -: 8];
    endfunction

    function automatic logic [7:0] rconFor(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] next_q, next_d;
    logic [127:0] ct_q, ct_d;
    logic         done_q, done_d;

    logic [31:0]  srCol;
    logic [31:0]  mixCol;
    logic [31:0]  colOut;
    logic [127:0] keyIn;
    logic [7:0]   rcon;
    logic [31:0]  rotSub;
    logic [127:0] keyOut;

    // ShiftRows + SubBytes + MixColumns + AddRoundKey for the current column
    always_comb begin
        srCol = '0;
        for (int r = 0; r < 4; r++) begin
            srCol[31 - 8*r -: 8] = sbox(getByte(state_q, {col_q + 2'(r), 2'(r)}));
        end
        mixCol = (round_q == 4'd10) ? srCol : mixColumn(srCol);
        colOut = mixCol ^ rk_q[127 - 32*int'(col_q) -: 32];
    end

    // One shared expander: from the cipher key on acceptance, else from rk_q
    always_comb begin
        keyIn  = (fsm_q == IDLE) ? bus.key : rk_q;
        rcon   = (fsm_q == IDLE) ? 8'h01 : rconFor(round_q + 4'd1);
        rotSub = {sbox(keyIn[23:16]), sbox(keyIn[15:8]), sbox(keyIn[7:0]), sbox(keyIn[31:24])}
                 ^ {rcon, 24'h000000};
        keyOut[127:96] = keyIn[127:96] ^ rotSub;
        keyOut[95:64]  = keyIn[95:64]  ^ keyOut[127:96];
        keyOut[63:32]  = keyIn[63:32]  ^ keyOut[95:64];
        keyOut[31:0]   = keyIn[31:0]   ^ keyOut[63:32];
    end

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        col_d   = col_q;
        state_d = state_q;
        rk_d    = rk_q;
        next_d  = next_q;
        ct_d    = ct_q;
        done_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (bus.start) begin
                    fsm_d   = ROUND;
                    state_d = bus.plaintext ^ bus.key;
                    rk_d    = keyOut;
                    round_d = 4'd1;
                    col_d   = 2'd0;
                end
            end
            ROUND: begin
                next_d[127 - 32*int'(col_q) -: 32] = colOut;
                if (col_q != 2'd3) begin
                    col_d = col_q + 2'd1;
                end else begin
                    // Column 3 bypasses next_q so a round closes without an extra cycle
                    col_d = 2'd0;
                    if (round_q == 4'd10) begin
                        ct_d   = {next_q[127:32], colOut};
                        done_d = 1'b1;
                        fsm_d  = IDLE;
                    end else begin
                        state_d = {next_q[127:32], colOut};
                        rk_d    = keyOut;
                        round_d = round_q + 4'd1;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            round_q <= 4'd0;
            col_q   <= 2'd0;
            state_q <= '0;
            rk_q    <= '0;
            next_q  <= '0;
            ct_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            col_q   <= col_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            next_q  <= next_d;
            ct_q    <= ct_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy       = (fsm_q == ROUND);
    assign bus.done       = done_q;
    assign bus.ciphertext = ct_q;

endmodule
